// File: rtl/pipe_minmax_node.sv
// pipe_minmax_node: combinational merge of two partial min/max records.
// The left child always covers the lower input indices, so strict compares
// make ties resolve toward the lowest index for both min and max.
module pipe_minmax_node #(
    parameter int p_nbits = 8,
    parameter int p_nidx  = 2
) (
    input  logic               sgn,
    input  logic [p_nbits-1:0] l_min,
    input  logic [p_nbits-1:0] l_max,
    input  logic [p_nidx-1:0]  l_min_idx,
    input  logic [p_nidx-1:0]  l_max_idx,
    input  logic [p_nbits-1:0] r_min,
    input  logic [p_nbits-1:0] r_max,
    input  logic [p_nidx-1:0]  r_min_idx,
    input  logic [p_nidx-1:0]  r_max_idx,
    output logic [p_nbits-1:0] m_min,
    output logic [p_nbits-1:0] m_max,
    output logic [p_nidx-1:0]  m_min_idx,
    output logic [p_nidx-1:0]  m_max_idx
);

    // One extra bit lets a single signed comparator serve both modes.
    function automatic logic less_than(input logic [p_nbits-1:0] a,
                                       input logic [p_nbits-1:0] b,
                                       input logic s);
        logic signed [p_nbits:0] ea;
        logic signed [p_nbits:0] eb;
        ea = s ? {a[p_nbits-1], a} : {1'b0, a};
        eb = s ? {b[p_nbits-1], b} : {1'b0, b};
        return ea < eb;
    endfunction

    // Pick the right child only when it strictly wins.
    always_comb begin
        m_min     = l_min;
        m_min_idx = l_min_idx;
        m_max     = l_max;
        m_max_idx = l_max_idx;
        if (less_than(r_min, l_min, sgn)) begin
            m_min     = r_min;
            m_min_idx = r_min_idx;
        end
        if (less_than(l_max, r_max, sgn)) begin
            m_max     = r_max;
            m_max_idx = r_max_idx;
        end
    end

endmodule

// File: rtl/pipe_minmax_reduce.sv
// pipe_minmax_reduce: pipelined min/max/argmin/argmax reduction tree.
// One register level per tree level; latency is log2(p_ninputs) cycles.
// All records of one level belong to the same vector, so the compare mode
// is carried as a single bit per level next to the valid bit.
module pipe_minmax_reduce #(
    parameter  int p_nbits   = 8,
    parameter  int p_ninputs = 4,
    localparam int p_nidx    = $clog2(p_ninputs)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_val,
    input  logic                         in_signed,
    input  logic [p_ninputs*p_nbits-1:0] in_,
    output logic                         out_val,
    output logic [p_nbits-1:0]           min,
    output logic [p_nbits-1:0]           max,
    output logic [p_nidx-1:0]            min_idx,
    output logic [p_nidx-1:0]            max_idx
);

    logic [p_nbits-1:0] leaf_val [p_ninputs];
    logic [p_nidx-1:0]  leaf_idx [p_ninputs];

    // Leaf records; data is forced to zero on idle cycles so X never reaches the tree.
    always_comb begin
        for (int i = 0; i < p_ninputs; i++) begin
            leaf_val[i] = in_val ? in_[i*p_nbits +: p_nbits] : '0;
            leaf_idx[i] = p_nidx'(i);
        end
    end

    for (genvar k = 1; k <= p_nidx; k++) begin : g_lvl
        localparam int n_nodes = p_ninputs >> k;

        logic               c_val;
        logic               c_sgn;
        logic [p_nbits-1:0] c_min     [2*n_nodes];
        logic [p_nbits-1:0] c_max     [2*n_nodes];
        logic [p_nidx-1:0]  c_min_idx [2*n_nodes];
        logic [p_nidx-1:0]  c_max_idx [2*n_nodes];

        logic [p_nbits-1:0] m_min     [n_nodes];
        logic [p_nbits-1:0] m_max     [n_nodes];
        logic [p_nidx-1:0]  m_min_idx [n_nodes];
        logic [p_nidx-1:0]  m_max_idx [n_nodes];

        logic               q_val;
        logic [p_nbits-1:0] q_min     [n_nodes];
        logic [p_nbits-1:0] q_max     [n_nodes];
        logic [p_nidx-1:0]  q_min_idx [n_nodes];
        logic [p_nidx-1:0]  q_max_idx [n_nodes];

        if (k == 1) begin : g_src
            // First level reads the leaves straight from the input vector.
            always_comb begin
                c_val = in_val;
                c_sgn = in_val & in_signed;
                for (int i = 0; i < 2*n_nodes; i++) begin
                    c_min[i]     = leaf_val[i];
                    c_max[i]     = leaf_val[i];
                    c_min_idx[i] = leaf_idx[i];
                    c_max_idx[i] = leaf_idx[i];
                end
            end
        end else begin : g_src
            // Deeper levels read the previous level's registers.
            always_comb begin
                c_val     = g_lvl[k-1].q_val;
                c_sgn     = g_lvl[k-1].g_sgn.q_sgn;
                c_min     = g_lvl[k-1].q_min;
                c_max     = g_lvl[k-1].q_max;
                c_min_idx = g_lvl[k-1].q_min_idx;
                c_max_idx = g_lvl[k-1].q_max_idx;
            end
        end

        for (genvar j = 0; j < n_nodes; j++) begin : g_node
            pipe_minmax_node #(
                .p_nbits (p_nbits),
                .p_nidx  (p_nidx)
            ) u_node (
                .sgn       (c_sgn),
                .l_min     (c_min[2*j]),
                .l_max     (c_max[2*j]),
                .l_min_idx (c_min_idx[2*j]),
                .l_max_idx (c_max_idx[2*j]),
                .r_min     (c_min[2*j+1]),
                .r_max     (c_max[2*j+1]),
                .r_min_idx (c_min_idx[2*j+1]),
                .r_max_idx (c_max_idx[2*j+1]),
                .m_min     (m_min[j]),
                .m_max     (m_max[j]),
                .m_min_idx (m_min_idx[j]),
                .m_max_idx (m_max_idx[j])
            );
        end

        // Valid advances every cycle; data only moves with a valid vector.
        always_ff @(posedge clk) begin
            if (reset) begin
                q_val <= 1'b0;
                for (int j = 0; j < n_nodes; j++) begin
                    q_min[j]     <= '0;
                    q_max[j]     <= '0;
                    q_min_idx[j] <= '0;
                    q_max_idx[j] <= '0;
                end
            end else begin
                q_val <= c_val;
                if (c_val) begin
                    for (int j = 0; j < n_nodes; j++) begin
                        q_min[j]     <= m_min[j];
                        q_max[j]     <= m_max[j];
                        q_min_idx[j] <= m_min_idx[j];
                        q_max_idx[j] <= m_max_idx[j];
                    end
                end
            end
        end

        if (k < p_nidx) begin : g_sgn
            logic q_sgn;
            // Compare mode follows its vector; the last level has no consumer for it.
            always_ff @(posedge clk) begin
                if (reset) begin
                    q_sgn <= 1'b0;
                end else if (c_val) begin
                    q_sgn <= c_sgn;
                end
            end
        end
    end

    assign out_val = g_lvl[p_nidx].q_val;
    assign min     = g_lvl[p_nidx].q_min[0];
    assign max     = g_lvl[p_nidx].q_max[0];
    assign min_idx = g_lvl[p_nidx].q_min_idx[0];
    assign max_idx = g_lvl[p_nidx].q_max_idx[0];

endmodule
